// File: rtl/spi_send_pkg.sv
// ---------------------------------------------------------------------------
// spi_send_pkg
// Shared types and helpers for spi_send_ctrl.
//   state_e    : controller FSM states (IDLE, OFFER, WAIT_DONE, GAP)
//   tmr_width  : width of the shared GAP / timeout down-counter, sized so it
//                can hold max(GAP_CYC, TMO_CYC)-1
// ---------------------------------------------------------------------------
package spi_send_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OFFER     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_e;

  // The counter is loaded with (cycles-1) and counts down to zero, so
  // $clog2 of the larger cycle count is always enough bits.
  function automatic int tmr_width(input int gap_cyc, input int tmo_cyc);
    int m;
    m = (gap_cyc > tmo_cyc) ? gap_cyc : tmo_cyc;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/spi_send_ctrl.sv
// ---------------------------------------------------------------------------
// spi_send_ctrl
// Keeps a data counter driven by button pulses and, on request, hands a
// snapshot of it to an SPI master over a valid/ready handshake, waits for the
// master's done strobe (with timeout), then enforces an inter-frame gap.
//
// Optional feature macro: SPI_SEND_AUTO_INC_EN
//   defined   : a done strobe accepted in WAIT_DONE also bumps the counter
//   undefined : the counter only moves on next_count_i
//
// Ports
//   clk_100       in   system clock
//   a_rst_n       in   asynchronous reset, active low
//   s_rst         in   synchronous reset, active high (same effect)
//   next_count_i  in   pulse: increment data counter
//   start_send_i  in   pulse: request one SPI transfer
//   spi_valid_o   out  word on spi_data_o is offered to the master
//   spi_data_o    out  word to transmit, frozen while offered
//   spi_ready_i   in   master accepts the word
//   spi_done_i    in   pulse: master finished the frame
//   busy_o        out  controller not in IDLE
//   cnt_o         out  current data counter
//   drop_o        out  pulse: a start request was ignored because busy
//   tmo_o         out  pulse: WAIT_DONE timed out
// ---------------------------------------------------------------------------
module spi_send_ctrl
  import spi_send_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int GAP_CYC = 16,
  parameter int TMO_CYC = 65535
) (
  input  logic              clk_100,
  input  logic              a_rst_n,
  input  logic              s_rst,
  input  logic              next_count_i,
  input  logic              start_send_i,
  output logic              spi_valid_o,
  output logic [DATA_W-1:0] spi_data_o,
  input  logic              spi_ready_i,
  input  logic              spi_done_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] cnt_o,
  output logic              drop_o,
  output logic              tmo_o
);

  localparam int TMR_W = tmr_width(GAP_CYC, TMO_CYC);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TMO_CYC - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              drop_q, drop_d;
  logic              tmo_q, tmo_d;

  // Data counter: advances in every state.
`ifdef SPI_SEND_AUTO_INC_EN
  logic done_acc;
  assign done_acc = (state_q == WAIT_DONE) && spi_done_i;
  assign cnt_d    = cnt_q + DATA_W'(next_count_i) + DATA_W'(done_acc);
`else
  assign cnt_d    = cnt_q + DATA_W'(next_count_i);
`endif

  // FSM next state. One down-counter serves both WAIT_DONE (timeout) and GAP;
  // it is loaded with cycles-1 on entry so the state lasts exactly that many
  // cycles when it expires at zero.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tmr_d   = tmr_q;
    drop_d  = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_send_i) begin
          state_d = OFFER;
          data_d  = cnt_q;  // value before any same-cycle increment
        end
      end
      OFFER: begin
        if (spi_ready_i) begin
          state_d = WAIT_DONE;
          tmr_d   = TMO_LOAD;
        end
      end
      WAIT_DONE: begin
        // done has priority over a timeout expiring on the same cycle
        if (spi_done_i) begin
          state_d = GAP;
          tmr_d   = GAP_LOAD;
        end else if (tmr_q == '0) begin
          state_d = GAP;
          tmr_d   = GAP_LOAD;
          tmo_d   = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      GAP: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start_send_i && (state_q != IDLE)) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      tmr_q   <= '0;
      drop_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else if (s_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      tmr_q   <= '0;
      drop_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      tmr_q   <= tmr_d;
      drop_q  <= drop_d;
      tmo_q   <= tmo_d;
    end
  end

  assign spi_valid_o = (state_q == OFFER);
  assign spi_data_o  = data_q;
  assign busy_o      = (state_q != IDLE);
  assign cnt_o       = cnt_q;
  assign drop_o      = drop_q;
  assign tmo_o       = tmo_q;

endmodule
